// File: rtl/branch_predictor_if.sv
// Fetch/resolve bus between the CPU pipeline and the branch predictor.
// The master is the pipeline; the slave is the predictor.
interface branch_predictor_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pred_target;
    logic                  resolve_valid;
    logic [ADDR_WIDTH-1:0] resolve_pc;
    logic                  resolve_taken;
    logic [ADDR_WIDTH-1:0] resolve_target;
    logic                  resolve_pred_taken;
    logic [ADDR_WIDTH-1:0] resolve_pred_target;
    logic                  rst_out;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [31:0]           mispredict_count;

    modport master (
        output fetch_pc, resolve_valid, resolve_pc, resolve_taken, resolve_target,
               resolve_pred_taken, resolve_pred_target,
        input  pred_taken, pred_target, rst_out, redirect_pc, mispredict_count
    );

    modport slave (
        input  fetch_pc, resolve_valid, resolve_pc, resolve_taken, resolve_target,
               resolve_pred_taken, resolve_pred_target,
        output pred_taken, pred_target, rst_out, redirect_pc, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, combinational
// lookup, execute-stage update, misprediction flush/redirect and a miss counter.
module branch_predictor #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic                 clk,
    input  logic                 rst_BF,
    branch_predictor_if.slave    bp
);
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
    localparam int ENTRIES  = 1 << INDEX_BITS;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [31:0] cnt_sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    logic [ENTRIES-1:0]    valid;
    logic [1:0]            ctr    [ENTRIES];
    logic [TAG_BITS-1:0]   tag    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target [ENTRIES];
    logic [31:0]           count;

    logic [INDEX_BITS-1:0] f_idx, r_idx;
    logic [TAG_BITS-1:0]   f_tag, r_tag;
    logic                  f_hit, r_hit, mispredict;

    assign f_idx = bp.fetch_pc[INDEX_BITS+1:2];
    assign f_tag = bp.fetch_pc[ADDR_WIDTH-1:INDEX_BITS+2];
    assign r_idx = bp.resolve_pc[INDEX_BITS+1:2];
    assign r_tag = bp.resolve_pc[ADDR_WIDTH-1:INDEX_BITS+2];

    // Lookup reads stored state only; same-cycle updates appear next cycle.
    always_comb begin
        f_hit          = valid[f_idx] && (tag[f_idx] == f_tag);
        r_hit          = valid[r_idx] && (tag[r_idx] == r_tag);
        bp.pred_taken  = f_hit && ctr[f_idx][1];
        bp.pred_target = bp.pred_taken ? target[f_idx] : bp.fetch_pc + ADDR_WIDTH'(4);
    end

    always_comb begin
        mispredict  = bp.resolve_valid &&
                      ((bp.resolve_taken != bp.resolve_pred_taken) ||
                       (bp.resolve_taken && (bp.resolve_target != bp.resolve_pred_target)));
        bp.rst_out     = mispredict;
        bp.redirect_pc = '0;
        if (mispredict)
            bp.redirect_pc = bp.resolve_taken ? bp.resolve_target
                                              : bp.resolve_pc + ADDR_WIDTH'(4);
    end

    always_ff @(posedge clk or posedge rst_BF) begin
        if (rst_BF) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
            count <= '0;
        end else begin
            if (bp.resolve_valid) begin
                if (r_hit) begin
                    ctr[r_idx] <= bp.resolve_taken ? ctr_inc(ctr[r_idx]) : ctr_dec(ctr[r_idx]);
                end else if (bp.resolve_taken) begin
                    valid[r_idx] <= 1'b1;
                    ctr[r_idx]   <= 2'b10;
                end
            end
            if (mispredict) count <= cnt_sat_inc(count);
        end
    end

    // Tag and target carry no reset; valid gates their use. A taken resolve
    // either refreshes the hit entry's target or allocates, so both writes coincide.
    always_ff @(posedge clk) begin
        if (!rst_BF && bp.resolve_valid && bp.resolve_taken) begin
            tag[r_idx]    <= r_tag;
            target[r_idx] <= bp.resolve_target;
        end
    end

    assign bp.mispredict_count = count;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;
    localparam int AW = 32;
    localparam int IB = 6;
    localparam logic [AW-1:0] ALIAS = 32'h100 + (32'd1 << (IB + 2));

    logic clk = 1'b0;
    logic rst_BF;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    branch_predictor_if #(.ADDR_WIDTH(AW)) bus ();

    branch_predictor #(.ADDR_WIDTH(AW), .INDEX_BITS(IB)) dut (
        .clk    (clk),
        .rst_BF (rst_BF),
        .bp     (bus)
    );

    task automatic drive_resolve(input logic [AW-1:0] pc, input logic taken,
                                 input logic [AW-1:0] tgt, input logic ptaken,
                                 input logic [AW-1:0] ptgt);
        bus.resolve_valid       = 1'b1;
        bus.resolve_pc          = pc;
        bus.resolve_taken       = taken;
        bus.resolve_target      = tgt;
        bus.resolve_pred_taken  = ptaken;
        bus.resolve_pred_target = ptgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.resolve_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_BF = 1'b1;
        bus.fetch_pc = 32'h100;
        bus.resolve_valid = 1'b0;
        bus.resolve_pc = '0; bus.resolve_taken = 1'b0; bus.resolve_target = '0;
        bus.resolve_pred_taken = 1'b0; bus.resolve_pred_target = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus.pred_taken !== 1'b0) begin fails++; $display("FAIL reset_pred_taken got %0d want 0", bus.pred_taken); end
        tests++; if (bus.pred_target !== 32'h104) begin fails++; $display("FAIL reset_pred_target got %h want 00000104", bus.pred_target); end
        tests++; if (bus.mispredict_count !== 32'd0) begin fails++; $display("FAIL reset_count got %0d want 0", bus.mispredict_count); end
        tests++; if (bus.rst_out !== 1'b0) begin fails++; $display("FAIL reset_rst_out got %0d want 0", bus.rst_out); end
        rst_BF = 1'b0;
        #1;
    endtask

    task automatic test_cold_allocate();
        drive_resolve(32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
        #1;
        tests++; if (bus.rst_out !== 1'b1) begin fails++; $display("FAIL cold_rst_out got %0d want 1", bus.rst_out); end
        tests++; if (bus.redirect_pc !== 32'h40) begin fails++; $display("FAIL cold_redirect got %h want 00000040", bus.redirect_pc); end
        tick();
        bus.fetch_pc = 32'h100;
        #1;
        tests++; if (bus.pred_taken !== 1'b1) begin fails++; $display("FAIL cold_pred_taken got %0d want 1", bus.pred_taken); end
        tests++; if (bus.pred_target !== 32'h40) begin fails++; $display("FAIL cold_pred_target got %h want 00000040", bus.pred_target); end
        tests++; if (bus.mispredict_count !== 32'd1) begin fails++; $display("FAIL cold_count got %0d want 1", bus.mispredict_count); end
        tests++; if (bus.rst_out !== 1'b0 || bus.redirect_pc !== 32'h0) begin fails++; $display("FAIL idle_redirect got %0d/%h want 0/00000000", bus.rst_out, bus.redirect_pc); end
    endtask

    task automatic test_saturation();
        // ctr 2 -> 3 -> 3 -> 3, all correctly predicted
        for (int i = 0; i < 3; i++) begin
            drive_resolve(32'h100, 1'b1, 32'h40, 1'b1, 32'h40);
            tick();
        end
        tests++; if (bus.mispredict_count !== 32'd1) begin fails++; $display("FAIL sat_count got %0d want 1", bus.mispredict_count); end
        drive_resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h40);
        #1;
        tests++; if (bus.redirect_pc !== 32'h104) begin fails++; $display("FAIL nt_redirect got %h want 00000104", bus.redirect_pc); end
        tick();
        tests++; if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h40) begin fails++; $display("FAIL hyst_pred got %0d/%h want 1/00000040", bus.pred_taken, bus.pred_target); end
        drive_resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h40);
        tick();
        tests++; if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h104) begin fails++; $display("FAIL hyst_flip got %0d/%h want 0/00000104", bus.pred_taken, bus.pred_target); end
        tests++; if (bus.mispredict_count !== 32'd3) begin fails++; $display("FAIL hyst_count got %0d want 3", bus.mispredict_count); end
    endtask

    task automatic test_alias();
        // ctr 1 -> 2 so the 0x100 entry predicts taken again
        drive_resolve(32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
        tick();
        drive_resolve(ALIAS, 1'b0, 32'h0, 1'b0, ALIAS + 32'd4);
        #1;
        tests++; if (bus.rst_out !== 1'b0) begin fails++; $display("FAIL alias_nt_rst_out got %0d want 0", bus.rst_out); end
        tick();
        bus.fetch_pc = 32'h100;
        #1;
        tests++; if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h40) begin fails++; $display("FAIL alias_keep got %0d/%h want 1/00000040", bus.pred_taken, bus.pred_target); end
        drive_resolve(ALIAS, 1'b1, 32'h80, 1'b0, ALIAS + 32'd4);
        tick();
        tests++; if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h104) begin fails++; $display("FAIL alias_evict got %0d/%h want 0/00000104", bus.pred_taken, bus.pred_target); end
        bus.fetch_pc = ALIAS;
        #1;
        tests++; if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h80) begin fails++; $display("FAIL alias_new got %0d/%h want 1/00000080", bus.pred_taken, bus.pred_target); end
        tests++; if (bus.mispredict_count !== 32'd5) begin fails++; $display("FAIL alias_count got %0d want 5", bus.mispredict_count); end
    endtask

    task automatic test_wrong_target();
        bus.fetch_pc = 32'h100;
        drive_resolve(32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
        tick();
        drive_resolve(32'h100, 1'b1, 32'h80, 1'b1, 32'h40);
        #1;
        tests++; if (bus.rst_out !== 1'b1 || bus.redirect_pc !== 32'h80) begin fails++; $display("FAIL wt_redirect got %0d/%h want 1/00000080", bus.rst_out, bus.redirect_pc); end
        tests++; if (bus.pred_target !== 32'h40) begin fails++; $display("FAIL wt_old_target got %h want 00000040", bus.pred_target); end
        tick();
        tests++; if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h80) begin fails++; $display("FAIL wt_new_target got %0d/%h want 1/00000080", bus.pred_taken, bus.pred_target); end
        tests++; if (bus.mispredict_count !== 32'd7) begin fails++; $display("FAIL wt_count got %0d want 7", bus.mispredict_count); end
    endtask

    task automatic test_collision();
        // ctr 3 -> 2, then a same-cycle resolve that takes it to 1
        drive_resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        tick();
        bus.fetch_pc = 32'h100;
        drive_resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        #1;
        tests++; if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h80) begin fails++; $display("FAIL coll_old got %0d/%h want 1/00000080", bus.pred_taken, bus.pred_target); end
        tick();
        tests++; if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h104) begin fails++; $display("FAIL coll_new got %0d/%h want 0/00000104", bus.pred_taken, bus.pred_target); end
        tests++; if (bus.mispredict_count !== 32'd9) begin fails++; $display("FAIL coll_count got %0d want 9", bus.mispredict_count); end
    endtask

    task automatic test_reset_mid_update();
        // Re-arm 0x100 to predict taken so the post-reset miss is observable
        drive_resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        tick();
        tests++; if (bus.pred_taken !== 1'b1) begin fails++; $display("FAIL pre_rst_pred got %0d want 1", bus.pred_taken); end
        @(negedge clk);
        drive_resolve(ALIAS, 1'b1, 32'h40, 1'b0, ALIAS + 32'd4);
        rst_BF = 1'b1;
        #1;
        tests++; if (bus.mispredict_count !== 32'd0 || bus.pred_taken !== 1'b0) begin fails++; $display("FAIL rst_async got %0d/%0d want 0/0", bus.mispredict_count, bus.pred_taken); end
        @(posedge clk);
        #1;
        rst_BF = 1'b0;
        bus.resolve_valid = 1'b0;
        #1;
        tests++; if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h104) begin fails++; $display("FAIL rst_miss100 got %0d/%h want 0/00000104", bus.pred_taken, bus.pred_target); end
        bus.fetch_pc = ALIAS;
        #1;
        tests++; if (bus.pred_taken !== 1'b0 || bus.pred_target !== ALIAS + 32'd4) begin fails++; $display("FAIL rst_miss_alias got %0d/%h want 0/%h", bus.pred_taken, bus.pred_target, ALIAS + 32'd4); end
        tests++; if (bus.mispredict_count !== 32'd0) begin fails++; $display("FAIL rst_count got %0d want 0", bus.mispredict_count); end
    endtask

    initial begin
        test_reset();
        test_cold_allocate();
        test_saturation();
        test_alias();
        test_wrong_target();
        test_collision();
        test_reset_mid_update();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
